// File: rtl/axi4lite_xbar_1to2.sv
// AXI4-Lite 1:2 address router: slave 0 main memory, slave 1 console UART.
// Unmapped accesses are answered locally with DECERR.
module axi4lite_xbar_1to2 #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] UART_BASE = 32'ha00003f8,
  parameter logic [ADDR_WIDTH-1:0] UART_MASK = 32'hfffffff8,
  parameter logic [ADDR_WIDTH-1:0] MEM_BASE  = 32'h80000000,
  parameter logic [ADDR_WIDTH-1:0] MEM_MASK  = 32'hf8000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    m_arvalid,
  output logic                    m_arready,
  input  logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic                    m_rvalid,
  input  logic                    m_rready,
  output logic [DATA_WIDTH-1:0]   m_rdata,
  output logic [1:0]              m_rresp,
  input  logic                    m_awvalid,
  output logic                    m_awready,
  input  logic [ADDR_WIDTH-1:0]   m_awaddr,
  input  logic                    m_wvalid,
  output logic                    m_wready,
  input  logic [DATA_WIDTH-1:0]   m_wdata,
  input  logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_bvalid,
  input  logic                    m_bready,
  output logic [1:0]              m_bresp,
  output logic                    s0_arvalid,
  input  logic                    s0_arready,
  output logic [ADDR_WIDTH-1:0]   s0_araddr,
  input  logic                    s0_rvalid,
  output logic                    s0_rready,
  input  logic [DATA_WIDTH-1:0]   s0_rdata,
  input  logic [1:0]              s0_rresp,
  output logic                    s0_awvalid,
  input  logic                    s0_awready,
  output logic [ADDR_WIDTH-1:0]   s0_awaddr,
  output logic                    s0_wvalid,
  input  logic                    s0_wready,
  output logic [DATA_WIDTH-1:0]   s0_wdata,
  output logic [DATA_WIDTH/8-1:0] s0_wstrb,
  input  logic                    s0_bvalid,
  output logic                    s0_bready,
  input  logic [1:0]              s0_bresp,
  output logic                    s1_arvalid,
  input  logic                    s1_arready,
  output logic [ADDR_WIDTH-1:0]   s1_araddr,
  input  logic                    s1_rvalid,
  output logic                    s1_rready,
  input  logic [DATA_WIDTH-1:0]   s1_rdata,
  input  logic [1:0]              s1_rresp,
  output logic                    s1_awvalid,
  input  logic                    s1_awready,
  output logic [ADDR_WIDTH-1:0]   s1_awaddr,
  output logic                    s1_wvalid,
  input  logic                    s1_wready,
  output logic [DATA_WIDTH-1:0]   s1_wdata,
  output logic [DATA_WIDTH/8-1:0] s1_wstrb,
  input  logic                    s1_bvalid,
  output logic                    s1_bready,
  input  logic [1:0]              s1_bresp
);

  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    R_IDLE, R_FWD, R_WAIT, R_ERR
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE, W_FWD, W_WAIT, W_ERR
  } w_state_t;

  // ---------------- read path ----------------
  r_state_t r_state, r_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic r_sel;
  logic ar_hit1, ar_hit0;
  logic sel_arready, sel_rvalid;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic [1:0] sel_rresp;

  // UART wins when the two windows overlap
  assign ar_hit1 = (m_araddr & UART_MASK) == UART_BASE;
  assign ar_hit0 = ~ar_hit1 &
    ((m_araddr & MEM_MASK) == MEM_BASE);

  assign sel_arready = r_sel ? s1_arready : s0_arready;
  assign sel_rvalid  = r_sel ? s1_rvalid  : s0_rvalid;
  assign sel_rdata   = r_sel ? s1_rdata   : s0_rdata;
  assign sel_rresp   = r_sel ? s1_rresp   : s0_rresp;

  assign s0_araddr = r_addr;
  assign s1_araddr = r_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_addr  <= '0;
      r_sel   <= 1'b0;
    end else begin
      r_state <= r_next;
      if (r_state == R_IDLE && m_arvalid) begin
        r_addr <= m_araddr;
        r_sel  <= ar_hit1;
      end
    end
  end

  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE:
        if (m_arvalid)
          r_next = (ar_hit1 | ar_hit0) ? R_FWD : R_ERR;
      R_FWD:
        if (sel_arready) r_next = R_WAIT;
      R_WAIT:
        if (sel_rvalid && m_rready) r_next = R_IDLE;
      R_ERR:
        if (m_rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    m_arready  = 1'b0;
    m_rvalid   = 1'b0;
    m_rdata    = '0;
    m_rresp    = 2'b00;
    s0_arvalid = 1'b0;
    s1_arvalid = 1'b0;
    s0_rready  = 1'b0;
    s1_rready  = 1'b0;
    unique case (r_state)
      R_IDLE: m_arready = ~rst;
      R_FWD: begin
        s0_arvalid = ~r_sel;
        s1_arvalid = r_sel;
      end
      R_WAIT: begin
        m_rvalid  = sel_rvalid;
        m_rdata   = sel_rdata;
        m_rresp   = sel_rresp;
        s0_rready = ~r_sel & m_rready;
        s1_rready = r_sel & m_rready;
      end
      R_ERR: begin
        m_rvalid = 1'b1;
        m_rresp  = 2'b11;
      end
      default: ;
    endcase
  end

  // ---------------- write path ----------------
  w_state_t w_state, w_next;
  logic aw_held, w_held, aw_done, w_done, w_sel;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [SW-1:0] w_strb;
  logic aw_hit1, aw_hit0;
  logic sel_awready, sel_wready, sel_bvalid;
  logic [1:0] sel_bresp;
  logic m_aw_hs, m_w_hs, s_aw_hs, s_w_hs, w_clear;

  assign aw_hit1 = (aw_addr & UART_MASK) == UART_BASE;
  assign aw_hit0 = ~aw_hit1 &
    ((aw_addr & MEM_MASK) == MEM_BASE);

  assign sel_awready = w_sel ? s1_awready : s0_awready;
  assign sel_wready  = w_sel ? s1_wready  : s0_wready;
  assign sel_bvalid  = w_sel ? s1_bvalid  : s0_bvalid;
  assign sel_bresp   = w_sel ? s1_bresp   : s0_bresp;

  assign m_aw_hs = m_awvalid & m_awready;
  assign m_w_hs  = m_wvalid & m_wready;
  assign s_aw_hs = (w_state == W_FWD) & ~aw_done & sel_awready;
  assign s_w_hs  = (w_state == W_FWD) & ~w_done & sel_wready;
  assign w_clear =
    ((w_state == W_WAIT) & sel_bvalid & m_bready) |
    ((w_state == W_ERR) & m_bready);

  assign s0_awaddr = aw_addr;
  assign s1_awaddr = aw_addr;
  assign s0_wdata  = w_data;
  assign s1_wdata  = w_data;
  assign s0_wstrb  = w_strb;
  assign s1_wstrb  = w_strb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_IDLE;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      w_sel   <= 1'b0;
      aw_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
    end else begin
      w_state <= w_next;
      if (m_aw_hs) begin
        aw_held <= 1'b1;
        aw_addr <= m_awaddr;
      end
      if (m_w_hs) begin
        w_held <= 1'b1;
        w_data <= m_wdata;
        w_strb <= m_wstrb;
      end
      if (w_state == W_IDLE && aw_held && w_held)
        w_sel <= aw_hit1;
      if (s_aw_hs) aw_done <= 1'b1;
      if (s_w_hs)  w_done  <= 1'b1;
      if (w_clear) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
    end
  end

  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE:
        if (aw_held && w_held)
          w_next = (aw_hit1 | aw_hit0) ? W_FWD : W_ERR;
      W_FWD:
        if ((aw_done | s_aw_hs) && (w_done | s_w_hs))
          w_next = W_WAIT;
      W_WAIT:
        if (sel_bvalid && m_bready) w_next = W_IDLE;
      W_ERR:
        if (m_bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    m_awready  = 1'b0;
    m_wready   = 1'b0;
    m_bvalid   = 1'b0;
    m_bresp    = 2'b00;
    s0_awvalid = 1'b0;
    s1_awvalid = 1'b0;
    s0_wvalid  = 1'b0;
    s1_wvalid  = 1'b0;
    s0_bready  = 1'b0;
    s1_bready  = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        m_awready = ~aw_held & ~rst;
        m_wready  = ~w_held & ~rst;
      end
      W_FWD: begin
        s0_awvalid = ~w_sel & ~aw_done;
        s1_awvalid = w_sel & ~aw_done;
        s0_wvalid  = ~w_sel & ~w_done;
        s1_wvalid  = w_sel & ~w_done;
      end
      W_WAIT: begin
        m_bvalid  = sel_bvalid;
        m_bresp   = sel_bresp;
        s0_bready = ~w_sel & m_bready;
        s1_bready = w_sel & m_bready;
      end
      W_ERR: begin
        m_bvalid = 1'b1;
        m_bresp  = 2'b11;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi4lite_xbar_1to2.sv
// Bench for axi4lite_xbar_1to2: behavioural slaves plus a
// queue scoreboard for master responses and slave-side beats.
module tb_axi4lite_xbar_1to2;

  localparam logic [31:0] UBASE = 32'ha00003f8;
  localparam logic [31:0] UMASK = 32'hfffffff8;
  localparam logic [31:0] MBASE = 32'h80000000;
  localparam logic [31:0] MMASK = 32'hf8000000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready;
  logic [31:0] m_araddr, m_awaddr, m_wdata;
  logic [3:0] m_wstrb;
  wire m_arready, m_rvalid, m_awready, m_wready, m_bvalid;
  wire [31:0] m_rdata;
  wire [1:0] m_rresp, m_bresp;

  wire [1:0] s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;
  wire [1:0][31:0] s_araddr, s_awaddr, s_wdata;
  wire [1:0][3:0] s_wstrb;
  logic [1:0] s_arready, s_rvalid, s_awready, s_wready, s_bvalid;
  logic [1:0][31:0] s_rdata;
  logic [1:0][1:0] s_rresp, s_bresp;

  axi4lite_xbar_1to2 dut (
    .clk(clk), .rst(rst),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_araddr(m_araddr),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_awaddr(m_awaddr),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_bresp(m_bresp),
    .s0_arvalid(s_arvalid[0]), .s0_arready(s_arready[0]),
    .s0_araddr(s_araddr[0]),
    .s0_rvalid(s_rvalid[0]), .s0_rready(s_rready[0]),
    .s0_rdata(s_rdata[0]), .s0_rresp(s_rresp[0]),
    .s0_awvalid(s_awvalid[0]), .s0_awready(s_awready[0]),
    .s0_awaddr(s_awaddr[0]),
    .s0_wvalid(s_wvalid[0]), .s0_wready(s_wready[0]),
    .s0_wdata(s_wdata[0]), .s0_wstrb(s_wstrb[0]),
    .s0_bvalid(s_bvalid[0]), .s0_bready(s_bready[0]),
    .s0_bresp(s_bresp[0]),
    .s1_arvalid(s_arvalid[1]), .s1_arready(s_arready[1]),
    .s1_araddr(s_araddr[1]),
    .s1_rvalid(s_rvalid[1]), .s1_rready(s_rready[1]),
    .s1_rdata(s_rdata[1]), .s1_rresp(s_rresp[1]),
    .s1_awvalid(s_awvalid[1]), .s1_awready(s_awready[1]),
    .s1_awaddr(s_awaddr[1]),
    .s1_wvalid(s_wvalid[1]), .s1_wready(s_wready[1]),
    .s1_wdata(s_wdata[1]), .s1_wstrb(s_wstrb[1]),
    .s1_bvalid(s_bvalid[1]), .s1_bready(s_bready[1]),
    .s1_bresp(s_bresp[1])
  );

  // ---------------- slave models ----------------
  int ar_delay[2], r_delay[2], aw_delay[2], w_delay[2], b_delay[2];
  logic [31:0] rdata_val[2];
  logic [1:0] rresp_val[2], bresp_val[2];
  int arcnt[2], rcnt[2], awcnt[2], wcnt[2], bcnt[2];
  logic [1:0] rbusy, aw_got, w_got;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_arready <= '0; s_rvalid <= '0;
      s_rdata <= '0; s_rresp <= '0;
      s_awready <= '0; s_wready <= '0;
      s_bvalid <= '0; s_bresp <= '0;
      rbusy <= '0; aw_got <= '0; w_got <= '0;
      for (int i = 0; i < 2; i++) begin
        arcnt[i] <= 0; rcnt[i] <= 0; awcnt[i] <= 0;
        wcnt[i] <= 0; bcnt[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (s_arvalid[i] && s_arready[i]) begin
          s_arready[i] <= 1'b0; rbusy[i] <= 1'b1;
          rcnt[i] <= 0; arcnt[i] <= 0;
        end else if (!rbusy[i]) begin
          if (!s_arvalid[i]) begin
            s_arready[i] <= (ar_delay[i] == 0); arcnt[i] <= 0;
          end else if (arcnt[i] >= ar_delay[i]) s_arready[i] <= 1'b1;
          else arcnt[i] <= arcnt[i] + 1;
        end
        if (s_rvalid[i]) begin
          if (s_rready[i]) begin
            s_rvalid[i] <= 1'b0; rbusy[i] <= 1'b0;
          end
        end else if (rbusy[i]) begin
          if (rcnt[i] >= r_delay[i]) begin
            s_rvalid[i] <= 1'b1;
            s_rdata[i] <= rdata_val[i];
            s_rresp[i] <= rresp_val[i];
          end else rcnt[i] <= rcnt[i] + 1;
        end
        if (s_awvalid[i] && s_awready[i]) begin
          s_awready[i] <= 1'b0; aw_got[i] <= 1'b1; awcnt[i] <= 0;
        end else if (!aw_got[i]) begin
          if (!s_awvalid[i]) begin
            s_awready[i] <= (aw_delay[i] == 0); awcnt[i] <= 0;
          end else if (awcnt[i] >= aw_delay[i]) s_awready[i] <= 1'b1;
          else awcnt[i] <= awcnt[i] + 1;
        end
        if (s_wvalid[i] && s_wready[i]) begin
          s_wready[i] <= 1'b0; w_got[i] <= 1'b1; wcnt[i] <= 0;
        end else if (!w_got[i]) begin
          if (!s_wvalid[i]) begin
            s_wready[i] <= (w_delay[i] == 0); wcnt[i] <= 0;
          end else if (wcnt[i] >= w_delay[i]) s_wready[i] <= 1'b1;
          else wcnt[i] <= wcnt[i] + 1;
        end
        if (s_bvalid[i]) begin
          if (s_bready[i]) begin
            s_bvalid[i] <= 1'b0; aw_got[i] <= 1'b0; w_got[i] <= 1'b0;
          end
        end else if (aw_got[i] && w_got[i]) begin
          if (bcnt[i] >= b_delay[i]) begin
            s_bvalid[i] <= 1'b1; s_bresp[i] <= bresp_val[i]; bcnt[i] <= 0;
          end else bcnt[i] <= bcnt[i] + 1;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct { logic [31:0] data; logic [1:0] resp; } rexp_t;
  typedef struct { int idx; logic [31:0] addr; } aexp_t;
  typedef struct { int idx; logic [31:0] data; logic [3:0] strb; } wexp_t;

  rexp_t rq[$];
  logic [1:0] bq[$];
  aexp_t sarq[$], sawq[$];
  wexp_t swq[$];

  int checks = 0, errors = 0, cyc = 0;
  logic ar_pend, aw_pend, w_pend, no_slave;
  int rblock, bblock, ar_fire_cyc, r_out, w_out;
  logic prev_rwait, prev_bwait;
  logic [31:0] prev_rdata;
  logic [1:0] prev_rresp, prev_bresp, prev_sarv, prev_sawv;

  function automatic int tb_decode(input logic [31:0] a);
    if ((a & UMASK) == UBASE) return 1;
    if ((a & MMASK) == MBASE) return 0;
    return -1;
  endfunction

  task automatic monitor();
    rexp_t re; aexp_t ae; wexp_t we; logic [1:0] be;
    if (m_arvalid && m_arready) begin
      checks++;
      if (r_out != 0) begin
        errors++; $display("FAIL ar_busy outstanding %0d need 0", r_out);
      end
      r_out++; ar_pend = 1'b0; ar_fire_cyc = cyc;
    end
    if (m_awvalid && m_awready) begin
      checks++;
      if (w_out != 0) begin
        errors++; $display("FAIL aw_busy outstanding %0d need 0", w_out);
      end
      w_out++; aw_pend = 1'b0;
    end
    if (m_wvalid && m_wready) w_pend = 1'b0;
    if (prev_rwait) begin
      checks++;
      if (!m_rvalid || m_rdata !== prev_rdata || m_rresp !== prev_rresp) begin
        errors++;
        $display("FAIL r_stable got v%b %h/%0d need v1 %h/%0d",
          m_rvalid, m_rdata, m_rresp, prev_rdata, prev_rresp);
      end
    end
    if (prev_bwait) begin
      checks++;
      if (!m_bvalid || m_bresp !== prev_bresp) begin
        errors++;
        $display("FAIL b_stable got v%b %0d need v1 %0d", m_bvalid, m_bresp, prev_bresp);
      end
    end
    if (m_rvalid && m_rready) begin
      checks++; r_out--;
      if (rq.size() == 0) begin
        errors++; $display("FAIL r_extra got %h need none", m_rdata);
      end else begin
        re = rq.pop_front();
        if (m_rdata !== re.data || m_rresp !== re.resp) begin
          errors++;
          $display("FAIL r_resp got %h/%0d need %h/%0d", m_rdata, m_rresp, re.data, re.resp);
        end
      end
    end
    if (m_bvalid && m_bready) begin
      checks++; w_out--;
      if (bq.size() == 0) begin
        errors++; $display("FAIL b_extra got %0d need none", m_bresp);
      end else begin
        be = bq.pop_front();
        if (m_bresp !== be) begin
          errors++; $display("FAIL b_resp got %0d need %0d", m_bresp, be);
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (s_arvalid[i] && !prev_sarv[i]) begin
        checks++;
        if (cyc != ar_fire_cyc + 1) begin
          errors++; $display("FAIL ar_lat got %0d need 1", cyc - ar_fire_cyc);
        end
      end
      if (s_awvalid[i] && !prev_sawv[i]) begin
        checks++;
        if (!s_wvalid[i]) begin
          errors++; $display("FAIL aw_w_together s%0d got wvalid 0 need 1", i);
        end
      end
      if (rbusy[i] || aw_got[i] || w_got[i]) begin
        checks++;
        if ((rbusy[i] && s_arvalid[i]) || (aw_got[i] && s_awvalid[i]) ||
            (w_got[i] && s_wvalid[i])) begin
          errors++;
          $display("FAIL valid_after_hs s%0d got ar%b aw%b w%b need 0",
            i, s_arvalid[i], s_awvalid[i], s_wvalid[i]);
        end
      end
      if (s_arvalid[i] && s_arready[i]) begin
        checks++;
        if (sarq.size() == 0) begin
          errors++; $display("FAIL s_ar_extra s%0d got %h need none", i, s_araddr[i]);
        end else begin
          ae = sarq.pop_front();
          if (ae.idx != i || s_araddr[i] !== ae.addr) begin
            errors++;
            $display("FAIL s_ar got s%0d %h need s%0d %h", i, s_araddr[i], ae.idx, ae.addr);
          end
        end
      end
      if (s_awvalid[i] && s_awready[i]) begin
        checks++;
        if (sawq.size() == 0) begin
          errors++; $display("FAIL s_aw_extra s%0d got %h need none", i, s_awaddr[i]);
        end else begin
          ae = sawq.pop_front();
          if (ae.idx != i || s_awaddr[i] !== ae.addr) begin
            errors++;
            $display("FAIL s_aw got s%0d %h need s%0d %h", i, s_awaddr[i], ae.idx, ae.addr);
          end
        end
      end
      if (s_wvalid[i] && s_wready[i]) begin
        checks++;
        if (swq.size() == 0) begin
          errors++; $display("FAIL s_w_extra s%0d got %h need none", i, s_wdata[i]);
        end else begin
          we = swq.pop_front();
          if (we.idx != i || s_wdata[i] !== we.data || s_wstrb[i] !== we.strb) begin
            errors++;
            $display("FAIL s_w got s%0d %h/%h need s%0d %h/%h",
              i, s_wdata[i], s_wstrb[i], we.idx, we.data, we.strb);
          end
        end
      end
    end
    if (no_slave) begin
      checks++;
      if (|{s_arvalid, s_awvalid, s_wvalid}) begin
        errors++;
        $display("FAIL no_slave got ar%b aw%b w%b need 0", s_arvalid, s_awvalid, s_wvalid);
      end
    end
    prev_rwait = m_rvalid && !m_rready;
    prev_rdata = m_rdata; prev_rresp = m_rresp;
    prev_bwait = m_bvalid && !m_bready;
    prev_bresp = m_bresp;
    prev_sarv = s_arvalid; prev_sawv = s_awvalid;
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    monitor();
    @(posedge clk);
    #1;
    m_arvalid = ar_pend; m_awvalid = aw_pend; m_wvalid = w_pend;
    if (rblock > 0) rblock--;
    if (bblock > 0) bblock--;
    m_rready = (rblock == 0); m_bready = (bblock == 0);
  endtask

  task automatic post_read(input logic [31:0] a);
    int idx = tb_decode(a);
    for (int n = 0; ar_pend && n < 200; n++) step();
    if (idx < 0) rq.push_back('{data: 32'h0, resp: 2'b11});
    else begin
      rq.push_back('{data: rdata_val[idx], resp: rresp_val[idx]});
      sarq.push_back('{idx: idx, addr: a});
    end
    ar_pend = 1'b1; m_arvalid = 1'b1; m_araddr = a;
  endtask

  task automatic drive_aw(input logic [31:0] a);
    for (int n = 0; aw_pend && n < 200; n++) step();
    aw_pend = 1'b1; m_awvalid = 1'b1; m_awaddr = a;
  endtask

  task automatic drive_w(input logic [31:0] d, input logic [3:0] s);
    for (int n = 0; w_pend && n < 200; n++) step();
    w_pend = 1'b1; m_wvalid = 1'b1; m_wdata = d; m_wstrb = s;
  endtask

  task automatic post_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int lead);
    int idx = tb_decode(a);
    if (idx < 0) bq.push_back(2'b11);
    else begin
      bq.push_back(bresp_val[idx]);
      sawq.push_back('{idx: idx, addr: a});
      swq.push_back('{idx: idx, data: d, strb: s});
    end
    if (lead >= 0) begin
      drive_w(d, s); repeat (lead) step(); drive_aw(a);
    end else begin
      drive_aw(a); repeat (-lead) step(); drive_w(d, s);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while ((rq.size() != 0 || bq.size() != 0 || ar_pend || aw_pend || w_pend)
           && n < 300) begin
      step(); n++;
    end
    checks++;
    if (n >= 300 || sarq.size() != 0 || sawq.size() != 0 || swq.size() != 0) begin
      errors++;
      $display("FAIL drain got r%0d b%0d sar%0d saw%0d sw%0d need 0",
        rq.size(), bq.size(), sarq.size(), sawq.size(), swq.size());
    end
  endtask

  task automatic set_slaves(input int ar, input int r, input int aw,
                            input int w, input int b);
    for (int i = 0; i < 2; i++) begin
      ar_delay[i] = ar; r_delay[i] = r; aw_delay[i] = aw;
      w_delay[i] = w; b_delay[i] = b;
      rresp_val[i] = 2'b00; bresp_val[i] = 2'b00;
    end
    step();
  endtask

  function automatic logic [111:0] outs();
    return {m_arready, m_rvalid, m_rdata, m_rresp, m_awready, m_wready,
            m_bvalid, m_bresp, s_arvalid, s_rready, s_awvalid, s_wvalid,
            s_bready, 64'h0};
  endfunction

  task automatic clear_tb();
    ar_pend = 0; aw_pend = 0; w_pend = 0;
    m_arvalid = 0; m_awvalid = 0; m_wvalid = 0;
    rq.delete(); bq.delete(); sarq.delete(); sawq.delete(); swq.delete();
    r_out = 0; w_out = 0; rblock = 0; bblock = 0;
    m_rready = 1; m_bready = 1;
    prev_rwait = 0; prev_bwait = 0; prev_sarv = '0; prev_sawv = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    clear_tb();
    m_araddr = '0; m_awaddr = '0; m_wdata = '0; m_wstrb = '0;
    no_slave = 0; ar_fire_cyc = 0;
    for (int i = 0; i < 2; i++) rdata_val[i] = '0;
    @(posedge clk); #1;
    checks++;
    if (outs() !== '0) begin
      errors++; $display("FAIL reset_outs got %h need 0", outs());
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({m_arready, m_awready, m_wready} !== 3'b111) begin
      errors++;
      $display("FAIL idle_ready got %b need 111", {m_arready, m_awready, m_wready});
    end
  endtask

  task automatic test_read_mem();
    set_slaves(0, 2, 0, 0, 0);
    rdata_val[0] = 32'hdeadbeef;
    post_read(32'h80000010);
    wait_done();
  endtask

  task automatic test_write_uart();
    set_slaves(0, 0, 0, 0, 3);
    post_write(32'ha00003f8, 32'h41, 4'h1, 2);
    wait_done();
  endtask

  task automatic test_split_aw_w();
    set_slaves(0, 0, 0, 4, 1);
    post_write(32'ha00003fc, 32'h42, 4'h2, 0);
    wait_done();
  endtask

  task automatic test_unmapped();
    set_slaves(0, 0, 0, 0, 0);
    no_slave = 1;
    post_read(32'h00001000);
    post_write(32'h10000000, 32'h77, 4'hf, 0);
    wait_done();
    no_slave = 0;
  endtask

  task automatic test_concurrent();
    set_slaves(0, 1, 1, 0, 1);
    rdata_val[0] = 32'h12345678;
    rblock = 5; bblock = 5; m_rready = 0; m_bready = 0;
    post_read(32'h80000100);
    post_write(32'ha00003f8, 32'h55, 4'h1, 0);
    post_read(32'h80000104);
    wait_done();
  endtask

  task automatic test_slverr();
    set_slaves(1, 0, 0, 1, 0);
    rresp_val[1] = 2'b10; rdata_val[1] = 32'h000000aa;
    bresp_val[0] = 2'b10;
    post_read(32'ha00003f9);
    post_write(32'h80000020, 32'hcafef00d, 4'hf, -1);
    wait_done();
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs[6];
    addrs = '{32'h80000000, 32'ha00003ff, 32'h87fffffc,
              32'h88000000, 32'ha00003f0, 32'h80001234};
    for (int k = 0; k < 6; k++) begin
      set_slaves($urandom_range(0, 2), $urandom_range(0, 3),
                 $urandom_range(0, 2), $urandom_range(0, 2),
                 $urandom_range(0, 2));
      rdata_val[0] = $urandom; rdata_val[1] = $urandom;
      post_read(addrs[k]);
      post_write(addrs[5 - k], $urandom, 4'($urandom_range(0, 15)),
                 int'($urandom_range(0, 4)) - 2);
      wait_done();
    end
  endtask

  task automatic test_midreset();
    set_slaves(0, 20, 20, 20, 0);
    rdata_val[0] = 32'h0badf00d;
    post_read(32'h80000030);
    post_write(32'ha00003f8, 32'h99, 4'h1, 0);
    repeat (6) step();
    checks++;
    if (s_awvalid[1] !== 1'b1 || m_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset got aw%b rv%b need aw1 rv0", s_awvalid[1], m_rvalid);
    end
    rst = 1'b1;
    clear_tb();
    #1;
    checks++;
    if (outs() !== '0) begin
      errors++; $display("FAIL midreset_outs got %h need 0", outs());
    end
    @(posedge clk); #1;
    rst = 1'b0;
    set_slaves(0, 1, 0, 0, 0);
    rdata_val[0] = 32'h600dcafe;
    post_read(32'h80000040);
    wait_done();
  endtask

  initial begin
    test_reset();
    test_read_mem();
    test_write_uart();
    test_split_aw_w();
    test_unmapped();
    test_concurrent();
    test_slverr();
    test_back_to_back();
    test_midreset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
